// File: rtl/mem_pkg.sv
`default_nettype none
// ======================================================================
// mem_pkg : shared types for the SRAM read-stream path.  Rev 1.0
// ======================================================================
package mem_pkg;

   localparam int MEM_WIDTH = 32;
   localparam int MEM_SIZE  = 256;
   localparam int MEM_AW    = $clog2(MEM_SIZE);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } rd_state_e;

   typedef logic [MEM_AW-1:0] mem_addr_t;
   typedef logic [MEM_AW:0]   mem_len_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ======================================================================
// sync_fifo : single-clock FIFO with occupancy count.  Rev 1.0
// ======================================================================
module sync_fifo #(
   parameter int  WIDTH = 32,
   parameter int  DEPTH = 4,
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CW-1:0]    count_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             w_push, w_pop;
   logic [PW-1:0]    w_wr_ptr_inc, w_rd_ptr_inc;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   // A push into a full FIFO is accepted only when a pop frees the slot.
   assign w_pop  = pop_i && !empty_o;
   assign w_push = push_i && (!full_o || w_pop);

   assign w_wr_ptr_inc = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
   assign w_rd_ptr_inc = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (w_push) begin
            mem_q[wr_ptr_q] <= data_i;
            wr_ptr_q        <= w_wr_ptr_inc;
         end
         if (w_pop) begin
            rd_ptr_q <= w_rd_ptr_inc;
         end
         case ({w_push, w_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_stream_reader.sv
`default_nettype none
// ======================================================================
// mem_stream_reader : sequential SRAM reader feeding a valid/ready stream.
// Rev 1.0
// ======================================================================
module mem_stream_reader
   import mem_pkg::*;
#(
   parameter int  WIDTH = MEM_WIDTH,
   parameter int  SIZE  = MEM_SIZE,
   parameter int  DEPTH = 4,
   localparam int AW    = $clog2(SIZE)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [AW-1:0]    base_addr_i,
   input  logic [AW:0]      len_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             mem_cenb_o,
   output logic             mem_wenb_o,
   output logic [AW-1:0]    mem_addr_o,
   input  logic [WIDTH-1:0] mem_q_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   input  logic             ready_i
);

   localparam int CW = $clog2(DEPTH + 1);

   rd_state_e     state_q, state_d;
   logic [AW-1:0] cur_addr_q, cur_addr_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW:0]   len_q, len_d;
   logic [AW:0]   issued_q, issued_d;
   logic [AW:0]   popped_q, popped_d;
   logic          cenb_q;
   logic          rd_pend_q;

   logic          w_issue, w_pop, w_last_pop;
   logic [AW-1:0] w_issue_addr, w_next_addr;
   logic [CW:0]   w_occ;
   logic [CW-1:0] w_fifo_count;
   logic          w_fifo_full, w_fifo_empty;

   assign mem_cenb_o = cenb_q;
   assign mem_wenb_o = 1'b1;
   assign mem_addr_o = addr_q;
   assign valid_o    = !w_fifo_empty;

   assign w_pop      = valid_o && ready_i;
   assign w_last_pop = w_pop && ((popped_q + 1'b1) == len_q);

   // Words committed but not yet popped: FIFO contents, the read presented to
   // the SRAM this cycle, and the read whose data is on mem_q_i this cycle.
   assign w_occ = {1'b0, w_fifo_count} + (CW+1)'(!cenb_q) + (CW+1)'(rd_pend_q);

   // The first read is decided in IDLE so it reaches the SRAM the cycle after start.
   assign w_issue_addr = (state_q == IDLE) ? base_addr_i : cur_addr_q;
   assign w_next_addr  = (w_issue_addr == AW'(SIZE - 1)) ? '0 : w_issue_addr + 1'b1;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = (len_i == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (w_last_pop) begin
               state_d = DONE;
            end else if (issued_q == len_q) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (w_last_pop) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      w_issue = 1'b0;
      busy_o  = 1'b0;
      done_o  = 1'b0;
      case (state_q)
         IDLE:  w_issue = start_i && (len_i != '0);
         RUN: begin
            busy_o  = 1'b1;
            w_issue = (issued_q < len_q) && (w_occ < (CW+1)'(DEPTH));
         end
         DRAIN: busy_o = 1'b1;
         DONE:  done_o = 1'b1;
         default: ;
      endcase
   end

   always_comb begin
      len_d      = len_q;
      issued_d   = issued_q;
      popped_d   = popped_q;
      cur_addr_d = cur_addr_q;
      addr_d     = addr_q;
      if (state_q == IDLE && start_i) begin
         len_d    = len_i;
         issued_d = '0;
         popped_d = '0;
      end
      if (w_issue) begin
         issued_d   = issued_d + 1'b1;
         addr_d     = w_issue_addr;
         cur_addr_d = w_next_addr;
      end
      if (w_pop) begin
         popped_d = popped_d + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cur_addr_q <= '0;
         addr_q     <= '0;
         len_q      <= '0;
         issued_q   <= '0;
         popped_q   <= '0;
         cenb_q     <= 1'b1;
         rd_pend_q  <= 1'b0;
      end else begin
         cur_addr_q <= cur_addr_d;
         addr_q     <= addr_d;
         len_q      <= len_d;
         issued_q   <= issued_d;
         popped_q   <= popped_d;
         cenb_q     <= !w_issue;
         rd_pend_q  <= !cenb_q;
         assert (!(rd_pend_q && w_fifo_full && !w_pop));
      end
   end

   // SRAM output is only valid the cycle after an access; rd_pend_q marks it.
   sync_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (rd_pend_q),
      .data_i  (mem_q_i),
      .pop_i   (w_pop),
      .data_o  (data_o),
      .full_o  (w_fifo_full),
      .empty_o (w_fifo_empty),
      .count_o (w_fifo_count)
   );

endmodule
`default_nettype wire

// File: tb/tb_mem_stream_reader.sv
`default_nettype none
// ======================================================================
// tb_mem_stream_reader : directed self-checking bench.  Rev 1.0
// ======================================================================
module tb_mem_stream_reader;

   localparam int WIDTH = 32;
   localparam int SIZE  = 256;
   localparam int DEPTH = 4;
   localparam int AW    = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic [AW-1:0]    base = '0;
   logic [AW:0]      len = '0;
   logic             busy, done, cenb, wenb, valid;
   logic             ready = 1'b0;
   logic [AW-1:0]    addr;
   logic [WIDTH-1:0] q = '0;
   logic [WIDTH-1:0] data;
   logic [WIDTH-1:0] sram [SIZE];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   // SRAM model: registered read, output holds when not enabled.
   always @(posedge clk) begin
      if (!cenb) q <= sram[addr];
   end

   mem_stream_reader #(
      .WIDTH (WIDTH),
      .SIZE  (SIZE),
      .DEPTH (DEPTH)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (start),
      .base_addr_i (base),
      .len_i       (len),
      .busy_o      (busy),
      .done_o      (done),
      .mem_cenb_o  (cenb),
      .mem_wenb_o  (wenb),
      .mem_addr_o  (addr),
      .mem_q_i     (q),
      .data_o      (data),
      .valid_o     (valid),
      .ready_i     (ready)
   );

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done got %b exp 0", done); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
      checks++; if (data !== '0)    begin errors++; $display("FAIL reset_data got %h exp 0", data); end
      checks++; if (cenb !== 1'b1)  begin errors++; $display("FAIL reset_cenb got %b exp 1", cenb); end
      checks++; if (wenb !== 1'b1)  begin errors++; $display("FAIL reset_wenb got %b exp 1", wenb); end
      checks++; if (addr !== '0)    begin errors++; $display("FAIL reset_addr got %h exp 0", addr); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   // Cycle-exact check of the len=8 transfer timeline.
   task automatic test_basic();
      int   nread = 0;
      logic ev, ed, eb, ec;
      base = '0; len = 9'd8; ready = 1'b1; start = 1'b1;
      for (int n = 1; n <= 12; n++) begin
         @(negedge clk);
         start = 1'b0;
         ev = (n >= 3 && n <= 10);
         ed = (n == 11);
         eb = (n <= 10);
         ec = !(n <= 8);
         checks++; if (valid !== ev) begin errors++; $display("FAIL basic_valid c%0d got %b exp %b", n, valid, ev); end
         if (ev) begin
            checks++;
            if (data !== 32'(100 + n - 3)) begin errors++; $display("FAIL basic_data c%0d got %0d exp %0d", n, data, 100 + n - 3); end
         end
         checks++; if (done !== ed) begin errors++; $display("FAIL basic_done c%0d got %b exp %b", n, done, ed); end
         checks++; if (busy !== eb) begin errors++; $display("FAIL basic_busy c%0d got %b exp %b", n, busy, eb); end
         checks++; if (cenb !== ec) begin errors++; $display("FAIL basic_cenb c%0d got %b exp %b", n, cenb, ec); end
         if (cenb === 1'b0) begin
            checks++;
            if (addr !== AW'(n - 1)) begin errors++; $display("FAIL basic_addr c%0d got %0d exp %0d", n, addr, n - 1); end
            nread++;
         end
      end
      checks++; if (nread != 8) begin errors++; $display("FAIL basic_nreads got %0d exp 8", nread); end
   endtask

   // Scoreboarded transfer with a repeating ready pattern and optional stray start.
   task automatic run_stream(input int b, input int l, input logic [3:0] rpat, input int glitch);
      int               words = 0;
      int               nread = 0;
      int               maxout = 0;
      int               cyc = 0;
      logic             prev_stall = 1'b0;
      logic             seen_done = 1'b0;
      logic [WIDTH-1:0] prev_data = '0;
      logic [WIDTH-1:0] exp_w;
      @(negedge clk);
      base = AW'(b); len = (AW+1)'(l); start = 1'b1; ready = rpat[0];
      while (!seen_done && cyc < 300) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (cyc == glitch) begin
            start = 1'b1; base = 8'd50; len = 9'd2;
         end
         if (prev_stall) begin
            checks++;
            if (valid !== 1'b1 || data !== prev_data) begin
               errors++; $display("FAIL stall_hold c%0d got v=%b d=%h exp v=1 d=%h", cyc, valid, data, prev_data);
            end
         end
         if (cenb === 1'b0) begin
            checks++;
            if (addr !== AW'((b + nread) % SIZE)) begin
               errors++; $display("FAIL rd_addr c%0d got %0d exp %0d", cyc, addr, (b + nread) % SIZE);
            end
            nread++;
         end
         if (nread - words > maxout) maxout = nread - words;
         ready = rpat[cyc % 4];
         if (valid === 1'b1 && ready) begin
            exp_w = 32'(100 + (b + words) % SIZE);
            checks++;
            if (data !== exp_w) begin errors++; $display("FAIL word%0d got %0d exp %0d", words, data, exp_w); end
            words++;
         end
         prev_stall = (valid === 1'b1) && !ready;
         prev_data  = data;
         if (done === 1'b1) begin
            seen_done = 1'b1;
            checks++; if (words != l) begin errors++; $display("FAIL words_at_done got %0d exp %0d", words, l); end
            checks++; if (nread != l) begin errors++; $display("FAIL reads_at_done got %0d exp %0d", nread, l); end
         end
      end
      checks++; if (!seen_done) begin errors++; $display("FAIL done_timeout got 0 exp 1"); end
      checks++; if (maxout > DEPTH) begin errors++; $display("FAIL outstanding got %0d exp <=%0d", maxout, DEPTH); end
      @(negedge clk);
      start = 1'b0;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse got %b exp 0", done); end
   endtask

   task automatic test_len0();
      logic ed;
      base = 8'd7; len = '0; start = 1'b1; ready = 1'b1;
      for (int n = 1; n <= 4; n++) begin
         @(negedge clk);
         start = 1'b0;
         ed = (n == 1);
         checks++; if (done !== ed)    begin errors++; $display("FAIL len0_done c%0d got %b exp %b", n, done, ed); end
         checks++; if (cenb !== 1'b1)  begin errors++; $display("FAIL len0_cenb c%0d got %b exp 1", n, cenb); end
         checks++; if (valid !== 1'b0) begin errors++; $display("FAIL len0_valid c%0d got %b exp 0", n, valid); end
         checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL len0_busy c%0d got %b exp 0", n, busy); end
      end
   endtask

   task automatic test_reset_mid();
      int pops = 0;
      int cyc = 0;
      @(negedge clk);
      base = '0; len = 9'd16; ready = 1'b1; start = 1'b1;
      while (pops < 5 && cyc < 50) begin
         @(negedge clk);
         cyc++;
         start = 1'b0;
         if (valid === 1'b1 && ready) pops++;
      end
      checks++; if (pops != 5) begin errors++; $display("FAIL rstmid_pops got %0d exp 5", pops); end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
      checks++; if (done !== 1'b0)  begin errors++; $display("FAIL rstmid_done got %b exp 0", done); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", valid); end
      checks++; if (data !== '0)    begin errors++; $display("FAIL rstmid_data got %h exp 0", data); end
      checks++; if (cenb !== 1'b1)  begin errors++; $display("FAIL rstmid_cenb got %b exp 1", cenb); end
      checks++; if (addr !== '0)    begin errors++; $display("FAIL rstmid_addr got %h exp 0", addr); end
      rst = 1'b0;
      run_stream(0, 4, 4'b1111, 0);
   endtask

   initial begin
      for (int i = 0; i < SIZE; i++) sram[i] = 32'(i + 100);
      test_reset();
      test_basic();
      @(negedge clk);
      run_stream(254, 4, 4'b1111, 0);
      run_stream(0, 8, 4'b1001, 0);
      run_stream(20, 10, 4'b0001, 0);
      test_len0();
      test_reset_mid();
      run_stream(10, 6, 4'b1111, 3);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
